edge_detec_multi: RTL and testbench

- Parametrised multi-channel successor to the single-input edge detector.
- Each of N_CH asynchronous inputs passes through a synchroniser and a programmable debounce filter, then into a per-channel edge-mode detector.
- Outputs per channel: single-cycle rise/fall pulses, a sticky event flag with software clear, and a saturating event counter.
- irq is the OR of all sticky flags; the block sits between raw GPIO/status pins and the control/status logic.

---
 rtl/edge_detec_pkg.sv | 19 +
 rtl/edge_chan.sv | 92 +++++++++
 rtl/edge_detec_multi.sv | 45 ++++
 tb/tb_edge_detec_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detec_pkg.sv
// Shared types and mode decode helpers for the multi-channel edge detector.
package edge_detec_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic mode_rise(input edge_mode_e m);
        return (m == EDGE_RISE) || (m == EDGE_BOTH);
    endfunction

    function automatic logic mode_fall(input edge_mode_e m);
        return (m == EDGE_FALL) || (m == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One input channel: synchroniser, debounce filter, edge detect, sticky flag
// and saturating event counter.
module edge_chan
    import edge_detec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_i,
    input  edge_mode_e       mode_i,
    input  logic [DEB_W-1:0] deb_len_i,
    input  logic             clr_i,
    output logic             re_o,
    output logic             fe_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_q, lvl_d, lvl_prev_q;
    logic [DEB_W-1:0]       dcnt_q, dcnt_d;
    logic                   re_q, re_d, fe_q, fe_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       ecnt_q, ecnt_d;
    logic                   s, hit;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], a_i};
        lvl_d  = lvl_q;
        dcnt_d = dcnt_q;
        if (s == lvl_q) begin
            dcnt_d = '0;
        end else if (dcnt_q >= deb_len_i) begin
            lvl_d  = s;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DEB_W'(1);
        end
    end

    // Edges are taken from the registered level one cycle after it moves.
    always_comb begin
        re_d     = lvl_q & ~lvl_prev_q & mode_rise(mode_i);
        fe_d     = ~lvl_q & lvl_prev_q & mode_fall(mode_i);
        hit      = re_d | fe_d;
        sticky_d = hit | (sticky_q & ~clr_i);
        ecnt_d   = ecnt_q;
        if (hit) begin
            if (clr_i)
                ecnt_d = CNT_W'(1);
            else if (ecnt_q != CNT_MAX)
                ecnt_d = ecnt_q + CNT_W'(1);
        end else if (clr_i) begin
            ecnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            dcnt_q     <= '0;
            re_q       <= 1'b0;
            fe_q       <= 1'b0;
            sticky_q   <= 1'b0;
            ecnt_q     <= '0;
        end else begin
            sync_q     <= sync_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            dcnt_q     <= dcnt_d;
            re_q       <= re_d;
            fe_q       <= fe_d;
            sticky_q   <= sticky_d;
            ecnt_q     <= ecnt_d;
        end
    end

    assign re_o     = re_q;
    assign fe_o     = fe_q;
    assign sticky_o = sticky_q;
    assign count_o  = ecnt_q;

endmodule

// File: rtl/edge_detec_multi.sv
// Multi-channel filtered edge detector: slices the buses into per-channel
// edge_chan instances and ORs the sticky flags into irq.
module edge_detec_multi
    import edge_detec_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       a_in,
    input  logic [2*N_CH-1:0]     edge_mode,
    input  logic [DEB_W-1:0]      debounce_len,
    input  logic [N_CH-1:0]       evt_clr,
    output logic [N_CH-1:0]       RE_detected,
    output logic [N_CH-1:0]       FE_detected,
    output logic [N_CH-1:0]       evt_sticky,
    output logic [N_CH*CNT_W-1:0] evt_count,
    output logic                  irq
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_W      (DEB_W),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .a_i      (a_in[i]),
            .mode_i   (edge_mode_e'(edge_mode[2*i +: 2])),
            .deb_len_i(debounce_len),
            .clr_i    (evt_clr[i]),
            .re_o     (RE_detected[i]),
            .fe_o     (FE_detected[i]),
            .sticky_o (evt_sticky[i]),
            .count_o  (evt_count[CNT_W*i +: CNT_W])
        );
    end

    assign irq = |evt_sticky;

endmodule

// File: tb/tb_edge_detec_multi.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops
// and checks them whenever any RE/FE output is high.
module tb_edge_detec_multi;

    localparam int N_CH = 4;
    localparam int SYNC = 2;
    localparam int DEB_W = 4;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       a_in;
    logic [2*N_CH-1:0]     edge_mode;
    logic [DEB_W-1:0]      debounce_len;
    logic [N_CH-1:0]       evt_clr;
    logic [N_CH-1:0]       RE_detected, FE_detected, evt_sticky;
    logic [N_CH*CNT_W-1:0] evt_count;
    logic                  irq;

    edge_detec_multi #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .DEB_W(DEB_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .edge_mode(edge_mode),
        .debounce_len(debounce_len), .evt_clr(evt_clr),
        .RE_detected(RE_detected), .FE_detected(FE_detected),
        .evt_sticky(evt_sticky), .evt_count(evt_count), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        bit rise;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt [N_CH];
    logic [1:0] mode_v [N_CH];
    logic [N_CH-1:0] a;
    int   dl_v;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cnt_of(input int ch);
        return int'(evt_count[CNT_W*ch +: CNT_W]);
    endfunction

    // Monitor: overdue entries are misses; every pulse must match the queue head.
    exp_t m;
    always @(negedge clk) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                total++; bad++;
                $display("FAIL missing pulse ch%0d: required at cyc=%0d, absent by cyc=%0d",
                         q[0].ch, q[0].cyc, cyc);
                void'(q.pop_front());
            end
            for (int i = 0; i < N_CH; i++) begin
                if (RE_detected[i] || FE_detected[i]) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected pulse ch%0d: re=%0b fe=%0b at cyc=%0d, none required",
                                 i, RE_detected[i], FE_detected[i], cyc);
                    end else begin
                        m = q.pop_front();
                        if (m.cyc != cyc || m.ch != i || RE_detected[i] != m.rise ||
                            FE_detected[i] != !m.rise || cnt_of(i) != m.cnt || !evt_sticky[i]) begin
                            bad++;
                            $display("FAIL pulse ch%0d: got cyc=%0d re=%0b fe=%0b cnt=%0d sticky=%0b, required ch%0d cyc=%0d rise=%0b cnt=%0d sticky=1",
                                     i, cyc, RE_detected[i], FE_detected[i], cnt_of(i), evt_sticky[i],
                                     m.ch, m.cyc, m.rise, m.cnt);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic set_mode();
        for (int i = 0; i < N_CH; i++) edge_mode[2*i +: 2] = mode_v[i];
    endtask

    task automatic push(input int ch, input bit rise, input int cnt);
        exp_t e;
        e.cyc = cyc + SYNC + 2 + dl_v;
        e.ch = ch; e.rise = rise; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic set_a(input int ch, input logic v);
        a[ch] = v;
        a_in = a;
    endtask

    // Flip a channel at the current negedge and predict its pulse, if reported.
    task automatic toggle(input int ch);
        set_a(ch, ~a[ch]);
        if (a[ch] ? mode_v[ch][0] : mode_v[ch][1]) begin
            exp_cnt[ch] = (exp_cnt[ch] == 255) ? 255 : exp_cnt[ch] + 1;
            push(ch, a[ch], exp_cnt[ch]);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() > 0; k++) @(negedge clk);
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d pulses still pending, required 0", q.size());
            q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; a = '0; a_in = '0; evt_clr = '0;
        dl_v = 0; debounce_len = '0;
        mode_v[0] = 2'b11; mode_v[1] = 2'b01; mode_v[2] = 2'b10; mode_v[3] = 2'b11;
        set_mode();
        for (int i = 0; i < N_CH; i++) exp_cnt[i] = 0;
        repeat (3) @(negedge clk);
        chk("reset RE", int'(RE_detected), 0);
        chk("reset FE", int'(FE_detected), 0);
        chk("reset sticky", int'(evt_sticky), 0);
        chk("reset count", int'(evt_count), 0);
        chk("reset irq", int'(irq), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // basic rise, no filtering
        toggle(0);
        drain();
        chk("basic sticky0", int'(evt_sticky[0]), 1);
        chk("basic count0", cnt_of(0), 1);
        chk("basic irq", int'(irq), 1);

        // glitch of 3 cycles with debounce 3 is dropped
        dl_v = 3; debounce_len = 4'd3;
        @(negedge clk);
        set_a(1, 1'b1);
        repeat (3) @(negedge clk);
        set_a(1, 1'b0);
        repeat (12) @(negedge clk);
        chk("glitch count1", cnt_of(1), 0);
        chk("glitch sticky1", int'(evt_sticky[1]), 0);

        // long pulse accepted once; fall is not reported in RISE mode
        toggle(1);
        repeat (10) @(negedge clk);
        drain();
        toggle(1);
        repeat (10) @(negedge clk);
        chk("accept count1", cnt_of(1), 1);

        // FALL mode ignores the rise
        toggle(2);
        repeat (6) @(negedge clk);
        toggle(2);
        drain();
        chk("mode count2", cnt_of(2), 1);

        // saturation on ch3
        dl_v = 0; debounce_len = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            toggle(3);
        end
        drain();
        chk("sat count3", cnt_of(3), 255);

        // clear coincident with a reported edge: edge wins
        toggle(3);
        q[q.size()-1].cnt = 1;
        exp_cnt[3] = 1;
        repeat (3) @(negedge clk);
        evt_clr[3] = 1'b1;
        @(negedge clk);
        evt_clr = '0;
        drain();
        chk("race sticky3", int'(evt_sticky[3]), 1);
        chk("race count3", cnt_of(3), 1);

        // plain clear on ch1
        evt_clr[1] = 1'b1;
        @(negedge clk);
        evt_clr = '0;
        exp_cnt[1] = 0;
        chk("clr sticky1", int'(evt_sticky[1]), 0);
        chk("clr count1", cnt_of(1), 0);
        chk("clr irq still set", int'(irq), 1);

        // clear all drops irq
        evt_clr = '1;
        @(negedge clk);
        evt_clr = '0;
        for (int i = 0; i < N_CH; i++) exp_cnt[i] = 0;
        chk("clrall irq", int'(irq), 0);
        chk("clrall count", int'(evt_count), 0);

        // simultaneous edges on ch0 and ch3
        toggle(0);
        toggle(3);
        drain();
        chk("simul count0", cnt_of(0), 1);
        chk("simul count3", cnt_of(3), 1);

        // reset in the middle of debouncing a rise on ch0
        dl_v = 3; debounce_len = 4'd3;
        repeat (4) @(negedge clk);
        set_a(0, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst RE", int'(RE_detected), 0);
        chk("midrst FE", int'(FE_detected), 0);
        chk("midrst sticky", int'(evt_sticky), 0);
        chk("midrst count", int'(evt_count), 0);
        chk("midrst irq", int'(irq), 0);
        reset = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            exp_cnt[i] = 0;
            if (a[i] && mode_v[i][0]) begin
                exp_cnt[i] = 1;
                push(i, 1'b1, 1);
            end
        end
        drain();
        repeat (10) @(negedge clk);
        chk("post-rst count0", cnt_of(0), 1);
        chk("post-rst irq", int'(irq), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
